// File: rtl/llc_lookup_pkg.sv
// pkg_line: shared geometry, line/set payload types and the request opcode
// for the last-level-cache tag lookup block.
package pkg_line;

  localparam int unsigned ADDR_SIZE   = 32;
  localparam int unsigned OFFSET_SIZE = 6;
  localparam int unsigned INDEX_SIZE  = 4;
  localparam int unsigned NUM_SETS    = 2 ** INDEX_SIZE;
  localparam int unsigned TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
  localparam int unsigned N_WAY       = 4;

  // One cache line's tag-array entry
  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_SIZE-1:0] tag;
  } line_st;

  // One set: all ways plus its tree-PLRU node bits
  typedef struct packed {
    line_st [N_WAY-1:0] way;
    logic   [N_WAY-2:0] plru_bits;
  } set_st;

  typedef enum logic [1:0] {
    OP_READ      = 2'd0,
    OP_WRITE     = 2'd1,
    OP_INVAL     = 2'd2,
    OP_CLEAR_ALL = 2'd3
  } llc_op_e;

endpackage

// File: rtl/llc_lookup_plru_tree.sv
// plru_tree: combinational tree-PLRU victim pick and access update.
// Node bits are heap ordered (node n has children 2n+1 / 2n+2); a node bit
// of 0 points the victim to the left subtree.
module plru_tree #(
  parameter  int unsigned N_WAY = 4,
  localparam int unsigned WAY_W = $clog2(N_WAY)
) (
  input  logic [N_WAY-2:0] bits_i,
  input  logic [WAY_W-1:0] access_i,
  output logic [WAY_W-1:0] victim_o,
  output logic [N_WAY-2:0] next_bits_o
);

  // Follow the node bits from the root down to the victim leaf
  always_comb begin : victim_walk
    int   node;
    logic dir;
    victim_o = '0;
    node     = 0;
    dir      = 1'b0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir = 1'b0;
      for (int n = 0; n < int'(N_WAY) - 1; n++) begin
        if (node == n) dir = bits_i[n];
      end
      victim_o[int'(WAY_W) - 1 - l] = dir;
      node = 2 * node + 1 + (dir ? 1 : 0);
    end
  end

  // Point every node on the accessed way's path away from it
  always_comb begin : update_walk
    int   node;
    logic dir;
    next_bits_o = bits_i;
    node        = 0;
    dir         = 1'b0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      dir = access_i[int'(WAY_W) - 1 - l];
      for (int n = 0; n < int'(N_WAY) - 1; n++) begin
        if (node == n) next_bits_o[n] = ~dir;
      end
      node = 2 * node + 1 + (dir ? 1 : 0);
    end
  end

endmodule

// File: rtl/llc_lookup.sv
// llc_lookup: set-associative tag lookup with tree-PLRU replacement.
// Request -> LOOKUP (compare + array write) -> UPDATE (response pulse).
// Optional feature macro: LLC_STATS_EN adds saturating hit/miss counters.
module llc_lookup
  import pkg_line::*;
#(
  parameter  int unsigned N_WAY      = pkg_line::N_WAY,
  parameter  int unsigned NUM_SETS   = pkg_line::NUM_SETS,
  parameter  int unsigned INDEX_SIZE = pkg_line::INDEX_SIZE,
  parameter  int unsigned TAG_SIZE   = pkg_line::TAG_SIZE,
  localparam int unsigned WAY_W      = $clog2(N_WAY)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  llc_op_e               req_op,
  input  logic [INDEX_SIZE-1:0] req_index,
  input  logic [TAG_SIZE-1:0]   req_tag,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [WAY_W-1:0]      rsp_way,
  output logic                  rsp_evict,
  output logic                  rsp_evict_dirty,
  output logic [TAG_SIZE-1:0]   rsp_evict_tag
`ifdef LLC_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  localparam logic [INDEX_SIZE-1:0] LAST_SET = INDEX_SIZE'(NUM_SETS - 1);

  state_e                  state_q, state_d;
  logic [INDEX_SIZE-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    clr_op_q, clr_op_d;
  llc_op_e                 op_q, op_d;
  logic [INDEX_SIZE-1:0]   index_q, index_d;
  logic [TAG_SIZE-1:0]     lkp_tag_q, lkp_tag_d;

  logic                    req_ready_q;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_hit_q, rsp_hit_d;
  logic [WAY_W-1:0]        rsp_way_q, rsp_way_d;
  logic                    rsp_evict_q, rsp_evict_d;
  logic                    rsp_evict_dirty_q, rsp_evict_dirty_d;
  logic [TAG_SIZE-1:0]     rsp_evict_tag_q, rsp_evict_tag_d;

  logic [N_WAY-1:0]        valid_q [NUM_SETS];
  logic [N_WAY-1:0]        dirty_q [NUM_SETS];
  logic [TAG_SIZE-1:0]     tags_q  [NUM_SETS][N_WAY];
  logic [N_WAY-2:0]        plru_q  [NUM_SETS];

  logic [N_WAY-1:0]        hit_vec;
  logic                    hit;
  logic [WAY_W-1:0]        hit_way;
  logic                    inv_found;
  logic [WAY_W-1:0]        inv_way;
  logic [WAY_W-1:0]        plru_victim;
  logic [WAY_W-1:0]        fill_way;
  logic [WAY_W-1:0]        acc_way;
  logic [N_WAY-2:0]        plru_next;
  logic                    victim_valid;
  logic                    accept;

  assign accept = req_valid && req_ready_q;

  // Parallel tag compare and lowest-invalid-way search on the latched set
  always_comb begin
    hit_vec   = '0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < int'(N_WAY); w++) begin
      hit_vec[w] = valid_q[index_q][w] && (tags_q[index_q][w] == lkp_tag_q);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    for (int w = int'(N_WAY) - 1; w >= 0; w--) begin
      if (!valid_q[index_q][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign hit          = |hit_vec;
  assign fill_way     = inv_found ? inv_way : plru_victim;
  assign acc_way      = hit ? hit_way : fill_way;
  assign victim_valid = !inv_found;

  plru_tree #(.N_WAY(N_WAY)) u_plru (
    .bits_i      (plru_q[index_q]),
    .access_i    (acc_way),
    .victim_o    (plru_victim),
    .next_bits_o (plru_next)
  );

  // Control state, latched request and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_CLEAR;
      clr_cnt_q         <= '0;
      clr_op_q          <= 1'b0;
      op_q              <= OP_READ;
      index_q           <= '0;
      lkp_tag_q         <= '0;
      req_ready_q       <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_hit_q         <= 1'b0;
      rsp_way_q         <= '0;
      rsp_evict_q       <= 1'b0;
      rsp_evict_dirty_q <= 1'b0;
      rsp_evict_tag_q   <= '0;
    end else begin
      state_q           <= state_d;
      clr_cnt_q         <= clr_cnt_d;
      clr_op_q          <= clr_op_d;
      op_q              <= op_d;
      index_q           <= index_d;
      lkp_tag_q         <= lkp_tag_d;
      req_ready_q       <= (state_d == ST_IDLE);
      rsp_valid_q       <= rsp_valid_d;
      rsp_hit_q         <= rsp_hit_d;
      rsp_way_q         <= rsp_way_d;
      rsp_evict_q       <= rsp_evict_d;
      rsp_evict_dirty_q <= rsp_evict_dirty_d;
      rsp_evict_tag_q   <= rsp_evict_tag_d;
    end
  end

  // Next state, request capture and response contents
  always_comb begin
    state_d           = state_q;
    clr_cnt_d         = clr_cnt_q;
    clr_op_d          = clr_op_q;
    op_d              = op_q;
    index_d           = index_q;
    lkp_tag_d         = lkp_tag_q;
    rsp_valid_d       = 1'b0;
    rsp_hit_d         = rsp_hit_q;
    rsp_way_d         = rsp_way_q;
    rsp_evict_d       = rsp_evict_q;
    rsp_evict_dirty_d = rsp_evict_dirty_q;
    rsp_evict_tag_d   = rsp_evict_tag_q;

    unique case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_SET) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
          clr_op_d  = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + INDEX_SIZE'(1);
        end
      end
      ST_IDLE: begin
        if (accept) begin
          op_d      = req_op;
          index_d   = req_index;
          lkp_tag_d = req_tag;
          if (req_op == OP_CLEAR_ALL) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            clr_op_d  = 1'b1;
          end else begin
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        state_d           = ST_UPDATE;
        rsp_valid_d       = 1'b1;
        rsp_evict_d       = 1'b0;
        rsp_evict_dirty_d = 1'b0;
        rsp_evict_tag_d   = '0;
        if (op_q == OP_INVAL) begin
          rsp_hit_d = hit;
          rsp_way_d = hit ? hit_way : '0;
        end else if (hit) begin
          rsp_hit_d = 1'b1;
          rsp_way_d = hit_way;
        end else begin
          rsp_hit_d         = 1'b0;
          rsp_way_d         = fill_way;
          rsp_evict_d       = victim_valid;
          rsp_evict_dirty_d = victim_valid && dirty_q[index_q][fill_way];
          rsp_evict_tag_d   = victim_valid ? tags_q[index_q][fill_way] : '0;
        end
      end
      ST_UPDATE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // A requested clear answers during its final CLEAR cycle
    if ((state_d == ST_CLEAR) && clr_op_d && (clr_cnt_d == LAST_SET)) begin
      rsp_valid_d       = 1'b1;
      rsp_hit_d         = 1'b0;
      rsp_way_d         = '0;
      rsp_evict_d       = 1'b0;
      rsp_evict_dirty_d = 1'b0;
      rsp_evict_tag_d   = '0;
    end
  end

  // Tag/state/PLRU array writes: clear walk or lookup result commit
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        valid_q[clr_cnt_q] <= '0;
        dirty_q[clr_cnt_q] <= '0;
        plru_q[clr_cnt_q]  <= '0;
        for (int w = 0; w < int'(N_WAY); w++) begin
          tags_q[clr_cnt_q][w] <= '0;
        end
      end else if (state_q == ST_LOOKUP) begin
        if (op_q == OP_INVAL) begin
          if (hit) begin
            valid_q[index_q][hit_way] <= 1'b0;
            dirty_q[index_q][hit_way] <= 1'b0;
          end
        end else if (hit) begin
          if (op_q == OP_WRITE) dirty_q[index_q][hit_way] <= 1'b1;
          plru_q[index_q] <= plru_next;
        end else begin
          valid_q[index_q][fill_way] <= 1'b1;
          dirty_q[index_q][fill_way] <= (op_q == OP_WRITE);
          tags_q[index_q][fill_way]  <= lkp_tag_q;
          plru_q[index_q]            <= plru_next;
        end
      end
    end
  end

`ifdef LLC_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Saturating READ/WRITE hit and miss counters, sampled on the UPDATE cycle
  always_ff @(posedge clk) begin
    if (rst || ((state_q == ST_IDLE) && accept && (req_op == OP_CLEAR_ALL))) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if ((state_q == ST_UPDATE) && (op_q != OP_INVAL)) begin
      if (rsp_hit_q) begin
        if (hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
      end else begin
        if (miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_hit         = rsp_hit_q;
  assign rsp_way         = rsp_way_q;
  assign rsp_evict       = rsp_evict_q;
  assign rsp_evict_dirty = rsp_evict_dirty_q;
  assign rsp_evict_tag   = rsp_evict_tag_q;

endmodule

// File: tb/tb_llc_lookup.sv
// tb_llc_lookup: directed self-checking bench for llc_lookup (4 ways, 16 sets).
module tb_llc_lookup;
  import pkg_line::*;

  localparam int unsigned WAY_W = $clog2(N_WAY);

  logic                  clk;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  llc_op_e               req_op;
  logic [INDEX_SIZE-1:0] req_index;
  logic [TAG_SIZE-1:0]   req_tag;
  logic                  rsp_valid;
  logic                  rsp_hit;
  logic [WAY_W-1:0]      rsp_way;
  logic                  rsp_evict;
  logic                  rsp_evict_dirty;
  logic [TAG_SIZE-1:0]   rsp_evict_tag;
`ifdef LLC_STATS_EN
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;
`endif

  int checks = 0;
  int errors = 0;

  int                  lat;
  logic                r_hit;
  logic [WAY_W-1:0]    r_way;
  logic                r_ev;
  logic                r_evd;
  logic [TAG_SIZE-1:0] r_etag;

  llc_lookup dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_index       (req_index),
    .req_tag         (req_tag),
    .rsp_valid       (rsp_valid),
    .rsp_hit         (rsp_hit),
    .rsp_way         (rsp_way),
    .rsp_evict       (rsp_evict),
    .rsp_evict_dirty (rsp_evict_dirty),
    .rsp_evict_tag   (rsp_evict_tag)
`ifdef LLC_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
    end
  endtask

  // Wait (bounded) for ready, issue one request, capture its response
  task automatic do_req(input llc_op_e op, input logic [INDEX_SIZE-1:0] idx,
                        input logic [TAG_SIZE-1:0] tag);
    int n;
    logic got;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_index = idx;
    req_tag   = tag;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 1) req_valid = 1'b0;
      if (rsp_valid) got = 1'b1;
    end
    r_hit  = rsp_hit;
    r_way  = rsp_way;
    r_ev   = rsp_evict;
    r_evd  = rsp_evict_dirty;
    r_etag = rsp_evict_tag;
  endtask

  task automatic expect_rsp(input string nm, input logic hit, input int way,
                            input logic ev, input logic evd, input logic [TAG_SIZE-1:0] etag);
    check({nm, ".latency"}, 64'(lat), 64'd2);
    check({nm, ".hit"}, 64'(r_hit), 64'(hit));
    check({nm, ".way"}, 64'(r_way), 64'(way));
    check({nm, ".evict"}, 64'(r_ev), 64'(ev));
    check({nm, ".evict_dirty"}, 64'(r_evd), 64'(evd));
    check({nm, ".evict_tag"}, 64'(r_etag), 64'(etag));
  endtask

  // CLEAR_ALL: one pulse, 16 cycles after acceptance, then ready again
  task automatic do_clear_all(input string nm);
    int n;
    int pulses;
    int first_lat;
    logic pulse_hit;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({nm, ".ready_wait"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = OP_CLEAR_ALL;
    req_index = '0;
    req_tag   = '0;
    @(posedge clk);
    pulses    = 0;
    first_lat = 0;
    pulse_hit = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (rsp_valid) begin
        pulses++;
        if (first_lat == 0) begin
          first_lat = k;
          pulse_hit = rsp_hit;
        end
      end
    end
    check({nm, ".pulses"}, 64'(pulses), 64'd1);
    check({nm, ".pulse_cycle"}, 64'(first_lat), 64'd16);
    check({nm, ".rsp_hit"}, 64'(pulse_hit), 64'd0);
    check({nm, ".ready_after"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int   cyc;
    logic seen;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_READ;
    req_index = '0;
    req_tag   = '0;

    // Reset values and clear length after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.req_ready", 64'(req_ready), 64'd0);
    check("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset.rsp_hit", 64'(rsp_hit), 64'd0);
    check("reset.rsp_way", 64'(rsp_way), 64'd0);
    check("reset.rsp_evict", 64'(rsp_evict), 64'd0);
    check("reset.rsp_evict_tag", 64'(rsp_evict_tag), 64'd0);
    rst = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!req_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) seen = 1'b1;
    end
    check("reset.clear_cycles", 64'(cyc), 64'd16);
    check("reset.no_rsp", 64'(seen), 64'd0);

    // Cold miss then hit in set 5
    do_req(OP_READ, 4'd5, 22'h12);
    expect_rsp("rd5_miss", 1'b0, 0, 1'b0, 1'b0, '0);
    do_req(OP_READ, 4'd5, 22'h12);
    expect_rsp("rd5_hit", 1'b1, 0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("pulse_width", 64'(rsp_valid), 64'd0);
    check("hold_hit", 64'(rsp_hit), 64'd1);

    // Fill set 3: A(W) B(R) C(W) D(R), rewrite A; PLRU then picks way 2 (C, dirty)
    do_req(OP_WRITE, 4'd3, 22'hA);
    expect_rsp("s3_fill_a", 1'b0, 0, 1'b0, 1'b0, '0);
    do_req(OP_READ, 4'd3, 22'hB);
    expect_rsp("s3_fill_b", 1'b0, 1, 1'b0, 1'b0, '0);
    do_req(OP_WRITE, 4'd3, 22'hC);
    expect_rsp("s3_fill_c", 1'b0, 2, 1'b0, 1'b0, '0);
    do_req(OP_READ, 4'd3, 22'hD);
    expect_rsp("s3_fill_d", 1'b0, 3, 1'b0, 1'b0, '0);
    do_req(OP_WRITE, 4'd3, 22'hA);
    expect_rsp("s3_write_a_hit", 1'b1, 0, 1'b0, 1'b0, '0);
    do_req(OP_READ, 4'd3, 22'hE);
    expect_rsp("s3_evict_c", 1'b0, 2, 1'b1, 1'b1, 22'hC);
    // Next victim walks root-left then right: way 1 (B, clean)
    do_req(OP_READ, 4'd3, 22'hF);
    expect_rsp("s3_evict_b", 1'b0, 1, 1'b1, 1'b0, 22'hB);

    // Invalidate hit, invalidate miss, refill same way
    do_req(OP_WRITE, 4'd7, 22'h3);
    expect_rsp("s7_write", 1'b0, 0, 1'b0, 1'b0, '0);
    do_req(OP_INVAL, 4'd7, 22'h3);
    expect_rsp("s7_inval_hit", 1'b1, 0, 1'b0, 1'b0, '0);
    do_req(OP_INVAL, 4'd7, 22'h4);
    expect_rsp("s7_inval_miss", 1'b0, 0, 1'b0, 1'b0, '0);
    do_req(OP_READ, 4'd7, 22'h3);
    expect_rsp("s7_reread", 1'b0, 0, 1'b0, 1'b0, '0);

    // Reset during LOOKUP of a WRITE aborts it
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_WRITE;
    req_index = 4'd9;
    req_tag   = 22'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check("abort.rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort.req_ready", 64'(req_ready), 64'd0);
    rst  = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!req_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) seen = 1'b1;
    end
    check("abort.clear_cycles", 64'(cyc), 64'd16);
    check("abort.no_rsp", 64'(seen), 64'd0);
    do_req(OP_READ, 4'd9, 22'h55);
    expect_rsp("abort_reread", 1'b0, 0, 1'b0, 1'b0, '0);
    do_req(OP_READ, 4'd5, 22'h12);
    expect_rsp("abort_wiped_s5", 1'b0, 0, 1'b0, 1'b0, '0);

    // Requested clear wipes the arrays
    do_req(OP_WRITE, 4'd4, 22'h77);
    expect_rsp("s4_write", 1'b0, 0, 1'b0, 1'b0, '0);
    do_clear_all("clear_all");
    do_req(OP_READ, 4'd4, 22'h77);
    expect_rsp("s4_after_clear", 1'b0, 0, 1'b0, 1'b0, '0);

`ifdef LLC_STATS_EN
    do_clear_all("stats_clear0");
    check("stats.hit_zero0", 64'(hit_count), 64'd0);
    check("stats.miss_zero0", 64'(miss_count), 64'd0);
    do_req(OP_READ, 4'd2, 22'h1);
    do_req(OP_READ, 4'd2, 22'h1);
    do_req(OP_WRITE, 4'd2, 22'h1);
    do_req(OP_READ, 4'd2, 22'h1);
    do_req(OP_READ, 4'd2, 22'h2);
    @(negedge clk);
    check("stats.hit_count", 64'(hit_count), 64'd3);
    check("stats.miss_count", 64'(miss_count), 64'd2);
    do_clear_all("stats_clear1");
    check("stats.hit_zero1", 64'(hit_count), 64'd0);
    check("stats.miss_zero1", 64'(miss_count), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
